// File: rtl/uart_tx_path.sv
// UART transmit path: small write-side FIFO feeding an 8N1-style serializer
// timed by a 16x oversample tick derived from the system clock.

module uart_tx_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          overflow
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && full) overflow <= 1'b1;
    end
  end
endmodule

module uart_tx_path #(
  parameter int CLK_MHZ   = 5,
  parameter int BAUD_RATE = 1200,
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int FIFO_AW   = 2
) (
  input  logic            clk,
  input  logic            uart_reset,
  input  logic            writeFlag,
  input  logic [DBIT-1:0] dataToSend,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            tx,
  output logic            tx_busy,
  output logic            uart_tx_done,
  output logic            overflow
);
  localparam int DIV  = (CLK_MHZ*1000000)/(BAUD_RATE*16);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   s, s_d;
  logic [NW-1:0]   n, n_d;
  logic [DBIT-1:0] shift, shift_d;
  logic [DBIT-1:0] head;
  logic [CW-1:0]   cnt;
  logic            tick, leave_idle, tx_d;

  assign leave_idle = (state == IDLE) && !fifo_empty;

  uart_tx_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst_n    (uart_reset),
    .wr       (writeFlag),
    .wdata    (dataToSend),
    .rd       (leave_idle),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // Divider restarts when a frame begins so frame length is exact.
  assign tick = (cnt == CW'(DIV-1));

  always_ff @(posedge clk or negedge uart_reset) begin
    if (!uart_reset)             cnt <= '0;
    else if (leave_idle || tick) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge uart_reset) begin
    if (!uart_reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      s     <= s_d;
      n     <= n_d;
      shift <= shift_d;
      tx    <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    s_d     = s;
    n_d     = n;
    shift_d = shift;
    case (state)
      IDLE: if (!fifo_empty) begin
        shift_d = head;
        s_d     = '0;
        state_d = START;
      end
      START: if (tick) begin
        if (s == SW'(15)) begin
          s_d     = '0;
          n_d     = '0;
          state_d = DATA;
        end else s_d = s + 1'b1;
      end
      DATA: if (tick) begin
        if (s == SW'(15)) begin
          s_d     = '0;
          shift_d = shift >> 1;
          if (n == NW'(DBIT-1)) state_d = STOP;
          else                  n_d = n + 1'b1;
        end else s_d = s + 1'b1;
      end
      STOP: if (tick) begin
        if (s == SW'(SB_TICK-1)) begin
          s_d     = '0;
          state_d = IDLE;
        end else s_d = s + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from next-state values so it tracks the state entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy      = (state != IDLE);
    uart_tx_done = (state == STOP) && tick && (s == SW'(SB_TICK-1));
  end
endmodule

// File: tb/tb_uart_tx_path.sv
// Directed bench for uart_tx_path: a line monitor decodes frames and compares
// them against a queue of bytes the stimulus expects to see transmitted.

module tb_uart_tx_path;
  logic       clk = 1'b0;
  logic       uart_reset;
  logic       writeFlag;
  logic [7:0] dataToSend;
  logic       fifo_full, fifo_empty, tx, tx_busy, uart_tx_done, overflow;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  bit mon_busy = 0;
  logic [7:0] exp_q [$];

  uart_tx_path #(.CLK_MHZ(1), .BAUD_RATE(15625), .DBIT(8), .SB_TICK(16), .FIFO_AW(2)) dut (
    .clk          (clk),
    .uart_reset   (uart_reset),
    .writeFlag    (writeFlag),
    .dataToSend   (dataToSend),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .uart_tx_done (uart_tx_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (uart_tx_done === 1'b1) done_cnt++;

  // Frame decoder: fall seen at E+0.5, mid-bit samples every 64 cycles.
  always begin : mon
    logic [7:0] rx;
    logic [7:0] want;
    @(negedge clk);
    if (mon_en && uart_reset && tx === 1'b0) begin
      mon_busy = 1;
      repeat (31) @(negedge clk);
      check("start_bit", tx, 0);
      for (int b = 0; b < 8; b++) begin
        repeat (64) @(negedge clk);
        rx[b] = tx;
      end
      repeat (64) @(negedge clk);
      check("stop_bit", tx, 1);
      check("frame_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("rx_byte", rx, want);
      end
      repeat (31) @(negedge clk);
      check("done_early", uart_tx_done, 0);
      @(negedge clk);
      check("done_pulse", uart_tx_done, 1);
      @(negedge clk);
      check("idle_gap_tx", tx, 1);
      check("idle_gap_busy", tx_busy, 0);
      mon_busy = 0;
    end
  end

  task automatic write_byte(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    writeFlag  = 1'b1;
    dataToSend = b;
    if (expect_tx) exp_q.push_back(b);
    @(negedge clk);
    writeFlag = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && !mon_busy && tx_busy === 1'b0 && fifo_empty === 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", k < budget, 1);
    @(negedge clk);
  endtask

  initial begin
    int  done_base;
    bit  saw_low;
    uart_reset = 1'b0;
    writeFlag  = 1'b0;
    dataToSend = '0;

    // reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", uart_tx_done, 0);
    uart_reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1;

    // single byte with exact start latency
    writeFlag = 1'b1; dataToSend = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    writeFlag = 1'b0;
    check("single_empty_after_wr", fifo_empty, 0);
    check("single_tx_still_idle", tx, 1);
    @(negedge clk);
    check("single_tx_fall", tx, 0);
    check("single_busy", tx_busy, 1);
    check("single_popped", fifo_empty, 1);
    wait_idle(2000);
    check("single_done_cnt", done_cnt, 1);

    // burst of four on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h55 : 8'h0F;
      writeFlag = 1'b1; dataToSend = v; exp_q.push_back(v);
      check("burst_not_full", fifo_full, 0);
      @(negedge clk);
    end
    writeFlag = 1'b0;
    check("burst_not_full_end", fifo_full, 0);
    wait_idle(5000);
    check("burst_done_cnt", done_cnt, 5);

    // overflow while a frame is in flight
    write_byte(8'h01, 1);
    @(negedge clk);
    check("ovf_fsm_busy", tx_busy, 1);
    check("ovf_fifo_drained", fifo_empty, 1);
    for (int i = 0; i < 5; i++) begin
      writeFlag = 1'b1; dataToSend = 8'(8'h11 + i);
      if (i < 4) exp_q.push_back(8'(8'h11 + i));
      if (i == 4) check("ovf_full_after_4", fifo_full, 1);
      @(negedge clk);
    end
    writeFlag = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_still_full", fifo_full, 1);
    wait_idle(6000);
    check("ovf_sticky", overflow, 1);
    check("ovf_done_cnt", done_cnt, 10);

    // pointer wrap: ten spaced writes
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(8'h30 + i), 1);
      wait_idle(2000);
    end
    check("wrap_empty", fifo_empty, 1);
    check("wrap_done_cnt", done_cnt, 20);

    // reset during data bit 3 of 0xC3 with two bytes queued
    mon_en = 0;
    @(negedge clk);
    writeFlag = 1'b1; dataToSend = 8'hC3;
    @(negedge clk); dataToSend = 8'h01;
    @(negedge clk); dataToSend = 8'h02;
    @(negedge clk); writeFlag = 1'b0;
    repeat (286) @(negedge clk);
    check("abort_pre_tx_bit3", tx, 0);
    check("abort_pre_queued", fifo_empty, 0);
    done_base = done_cnt;
    uart_reset = 1'b0;
    #1;
    check("abort_tx_high", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_empty", fifo_empty, 1);
    check("abort_ovf_clr", overflow, 0);
    repeat (3) @(negedge clk);
    uart_reset = 1'b1;
    saw_low = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1;
    end
    check("abort_line_idle", saw_low, 0);
    check("abort_no_done", done_cnt, done_base);
    check("abort_empty_after", fifo_empty, 1);
    check("abort_busy_after", tx_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_path.md
Name: uart_tx_path

Overview:
- Transmit-direction companion to the UART receive path. Buffers outgoing bytes in a small write-side FIFO and serializes them onto `tx` as 8N1-style frames.
- Frames use an internal 16x-oversampled baud tick, so the host can queue several bytes without waiting on each frame.
- Sits beside the receive path in the UART top; its clock and reset come from the same domain.

Parameters:
- CLK_MHZ, 5: system clock frequency in MHz.
- BAUD_RATE, 1200: line baud rate.
- DBIT, 8: data bits per frame.
- SB_TICK, 16: stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW (default 4).

Ports:
- clk  in  1  system clock, rising edge.
- uart_reset  in  1  asynchronous, active-low reset (0 = reset).
- writeFlag  in  1  push `dataToSend` into the FIFO this cycle.
- dataToSend  in  DBIT  byte to queue.
- fifo_full  out  1  FIFO holds 2**FIFO_AW entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- tx  out  1  serial line output, registered, idle high.
- tx_busy  out  1  FSM not in IDLE.
- uart_tx_done  out  1  one-cycle pulse at the end of each frame's stop bit.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset is asynchronous and active-low. While `uart_reset` = 0:
  - `tx` = 1, `tx_busy` = 0, `uart_tx_done` = 0, `overflow` = 0.
  - `fifo_empty` = 1, `fifo_full` = 0.
  - FIFO pointers, tick divider and FSM all cleared.
- Tick divider:
  - DIV = (CLK_MHZ*1000000)/(BAUD_RATE*16), integer floor.
  - Counter runs 0..DIV-1. `tick` is asserted in the cycle the counter = DIV-1.
  - The counter is forced to 0 in the cycle the FSM leaves IDLE, so every frame is exactly (1+DBIT)*16*DIV + SB_TICK*DIV cycles long.
- FIFO (registered, first-word-fall-through to the FSM):
  - A write with `writeFlag`=1 and not full stores the byte at the write pointer.
  - A write while full is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle; `fifo_full` is the value before the edge.
  - A simultaneous write and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo depth. Full and empty are derived from an occupancy count of width FIFO_AW+1.
- FSM states IDLE, START, DATA, STOP; oversample counter s (0..15, or 0..SB_TICK-1 in STOP); bit counter n (0..DBIT-1):
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, set s=0, go to START.
  - START: `tx`=0. On tick, s++. On the tick where s=15, set s=0 and go to DATA with n=0.
  - DATA: `tx` = shift[0] (LSB first). On the tick where s=15, shift right and set s=0. If n=DBIT-1, go to STOP; otherwise n++.
  - STOP: `tx`=1. On the tick where s=SB_TICK-1, pulse `uart_tx_done` for that cycle and go to IDLE.
- `tx` is registered, so it reflects the state entered at the same edge.
  - A byte written at edge N into an empty FIFO with the FSM idle gives `fifo_empty`=0 after N, a pop at N+1, and `tx` falling at N+1.
- Back-to-back frames: IDLE occupies exactly one cycle between the `uart_tx_done` pulse and the next start bit.
- Writes are accepted in every state. Data in the shift register is never altered by FIFO activity.
- Reset asserted mid-frame aborts the frame immediately: `tx`=1 and queued data is discarded. No `uart_tx_done` is issued for the aborted frame.

Test Plan (CLK_MHZ=1, BAUD_RATE=15625, so DIV=4 and one bit = 64 cycles, SB_TICK=16, frame = 640 cycles):
- Reset check: hold `uart_reset`=0 for 5 cycles -> `tx`=1, `fifo_empty`=1, `fifo_full`=0, `tx_busy`=0, `overflow`=0.
- Single byte: write 0xA5 -> `tx` falls 2 edges after the write. Sample mid-bit every 64 cycles: 0 (start), 1,0,1,0,0,1,0,1, then 1 (stop). `uart_tx_done` pulses once 640 cycles after the fall.
- Burst/back-to-back: write 0x00,0xFF,0x55,0x0F on consecutive cycles -> `fifo_full`=0 throughout, because the first pop frees a slot. Four frames come out in order with one idle cycle between stop and next start, giving four `uart_tx_done` pulses.
- Overflow: hold the FSM busy, then write 5 bytes (0x11..0x15) -> `fifo_full`=1 after the 4th write. 0x15 is dropped and `overflow`=1 stays set. Transmitted sequence is 0x01 (the in-flight byte) followed by 0x11..0x14.
- Wrap-around: 10 single writes spaced one frame apart, values 0x30..0x39 -> all bytes received in order and `fifo_empty`=1 at the end.
- Reset mid-frame: assert reset during DATA bit 3 of 0xC3 with 2 bytes queued -> `tx`=1 immediately. After release: no `uart_tx_done`, `fifo_empty`=1, line stays idle.
